collision_arbiter: RTL and testbench

COLLISION_ARBITER -- requirements
Module: collision_arbiter

---
 rtl/collision_pkg.sv | 26 ++
 rtl/hit_priority_encoder.sv | 25 ++
 rtl/collision_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_collision_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and constants for the monkey/object collision arbiter.
// Holds the arbiter state encoding, hit classification and counter widths.
package collision_pkg;

  localparam int HIT_IDX_W   = 4;
  localparam int MAX_OBJECTS = 1 << HIT_IDX_W;
  localparam int HIT_CNT_W   = 8;
  localparam int CD_CNT_W    = 4;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    HIT_TAKEN = 2'd1,
    COOLDOWN  = 2'd2
  } arb_state_t;

  typedef enum logic {
    HIT_NUMBER  = 1'b0,
    HIT_OPERAND = 1'b1
  } hit_type_t;

  // Saturating increment; sticks at all-ones.
  function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hit_priority_encoder.sv
// Lowest-index-wins priority encoder: reports whether any request is set and
// the index of the lowest set request.
module hit_priority_encoder
  import collision_pkg::*;
#(
  parameter int WIDTH = 3
)(
  input  logic [WIDTH-1:0]     req,
  output logic                 valid,
  output logic [HIT_IDX_W-1:0] index
);

  // Scan from the top down so the last match (the lowest index) sticks.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = HIT_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/collision_arbiter.sv
// Turns monkey-vs-object pixel overlaps into single registered hit pulses with a
// frame-based cooldown, and summarises terrain overlaps once per frame.
module collision_arbiter
  import collision_pkg::*;
#(
  parameter int NUMBERS         = 3,
  parameter int OPERANDS        = 2,
  parameter int COOLDOWN_FRAMES = 2
)(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 drawing_request_Monkey,
  input  logic [NUMBERS-1:0]   drawing_request_Numbers,
  input  logic [OPERANDS-1:0]  drawing_request_Operands,
  input  logic                 drawing_request_Rope,
  input  logic                 drawing_request_Block,
  input  logic                 drawing_request_Water,
  output logic [NUMBERS-1:0]   SingleHitPulse,
  output logic [OPERANDS-1:0]  operandHit,
  output logic                 hitValid,
  output logic                 hitIsOperand,
  output logic [HIT_IDX_W-1:0] hitIndex,
  output logic                 ropeCollision,
  output logic                 blockCollision,
  output logic                 waterCollision,
  output logic [HIT_CNT_W-1:0] hitCount,
  output logic                 inCooldown
);

  if (NUMBERS < 1 || NUMBERS > MAX_OBJECTS) begin : g_bad_numbers
    $error("collision_arbiter: NUMBERS must be in 1..16");
  end
  if (OPERANDS < 1 || OPERANDS > MAX_OBJECTS) begin : g_bad_operands
    $error("collision_arbiter: OPERANDS must be in 1..16");
  end
  if (COOLDOWN_FRAMES < 0 || COOLDOWN_FRAMES > 15) begin : g_bad_cooldown
    $error("collision_arbiter: COOLDOWN_FRAMES must be in 0..15");
  end

  logic [NUMBERS-1:0]   num_overlap;
  logic [OPERANDS-1:0]  op_overlap;
  logic                 num_valid;
  logic                 op_valid;
  logic [HIT_IDX_W-1:0] num_idx;
  logic [HIT_IDX_W-1:0] op_idx;

  assign num_overlap = drawing_request_Numbers  & {NUMBERS{drawing_request_Monkey}};
  assign op_overlap  = drawing_request_Operands & {OPERANDS{drawing_request_Monkey}};

  hit_priority_encoder #(.WIDTH(NUMBERS)) u_num_enc (
    .req   (num_overlap),
    .valid (num_valid),
    .index (num_idx)
  );

  hit_priority_encoder #(.WIDTH(OPERANDS)) u_op_enc (
    .req   (op_overlap),
    .valid (op_valid),
    .index (op_idx)
  );

  arb_state_t           state_reg;
  arb_state_t           state_next;
  logic [CD_CNT_W-1:0]  cd_cnt_reg;
  logic [CD_CNT_W-1:0]  cd_cnt_next;
  logic                 accept;
  hit_type_t            hit_type;
  logic [HIT_IDX_W-1:0] sel_idx;

  // Numbers always beat operands when both overlap in the same pixel.
  assign accept   = (state_reg == ARMED) && !startOfFrame && (num_valid || op_valid);
  assign hit_type = num_valid ? HIT_NUMBER : HIT_OPERAND;
  assign sel_idx  = num_valid ? num_idx : op_idx;

  always_comb begin
    state_next  = state_reg;
    cd_cnt_next = cd_cnt_reg;
    case (state_reg)
      ARMED: begin
        if (accept) begin
          state_next  = HIT_TAKEN;
          cd_cnt_next = CD_CNT_W'(COOLDOWN_FRAMES);
        end
      end
      HIT_TAKEN: begin
        if (startOfFrame) begin
          state_next = (cd_cnt_reg == '0) ? ARMED : COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          if (cd_cnt_reg != '0) begin
            cd_cnt_next = cd_cnt_reg - 1'b1;
          end
          if (cd_cnt_reg <= CD_CNT_W'(1)) begin
            state_next = ARMED;
          end
        end
      end
      default: begin
        state_next  = ARMED;
        cd_cnt_next = '0;
      end
    endcase
  end

  logic [NUMBERS-1:0]  num_pulse_next;
  logic [OPERANDS-1:0] op_pulse_next;

  for (genvar gi = 0; gi < NUMBERS; gi++) begin : g_num_pulse
    assign num_pulse_next[gi] = accept && (hit_type == HIT_NUMBER) &&
                                (num_idx == HIT_IDX_W'(gi));
  end

  for (genvar gi = 0; gi < OPERANDS; gi++) begin : g_op_pulse
    assign op_pulse_next[gi] = accept && (hit_type == HIT_OPERAND) &&
                               (op_idx == HIT_IDX_W'(gi));
  end

  // Terrain bits ordered {rope, block, water}; startOfFrame pixels never count.
  logic [2:0] terr_px;
  logic [2:0] terr_acc_reg;
  logic [2:0] terr_acc_next;
  logic [2:0] terr_sum_reg;
  logic [2:0] terr_sum_next;

  assign terr_px = {drawing_request_Rope, drawing_request_Block, drawing_request_Water} &
                   {3{drawing_request_Monkey && !startOfFrame}};

  always_comb begin
    terr_acc_next = terr_acc_reg | terr_px;
    terr_sum_next = terr_sum_reg;
    if (startOfFrame) begin
      terr_sum_next = terr_acc_reg;
      terr_acc_next = '0;
    end
  end

  logic [NUMBERS-1:0]   num_pulse_reg;
  logic [OPERANDS-1:0]  op_pulse_reg;
  logic                 hit_valid_reg;
  logic                 hit_is_op_reg;
  logic [HIT_IDX_W-1:0] hit_idx_reg;
  logic [HIT_CNT_W-1:0] hit_cnt_reg;
  logic                 in_cd_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= ARMED;
      cd_cnt_reg    <= '0;
      terr_acc_reg  <= '0;
      terr_sum_reg  <= '0;
      num_pulse_reg <= '0;
      op_pulse_reg  <= '0;
      hit_valid_reg <= 1'b0;
      hit_is_op_reg <= 1'b0;
      hit_idx_reg   <= '0;
      hit_cnt_reg   <= '0;
      in_cd_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cd_cnt_reg    <= cd_cnt_next;
      terr_acc_reg  <= terr_acc_next;
      terr_sum_reg  <= terr_sum_next;
      num_pulse_reg <= num_pulse_next;
      op_pulse_reg  <= op_pulse_next;
      hit_valid_reg <= accept;
      hit_is_op_reg <= accept && (hit_type == HIT_OPERAND);
      hit_idx_reg   <= accept ? sel_idx : '0;
      if (accept) begin
        hit_cnt_reg <= sat_inc(hit_cnt_reg);
      end
      in_cd_reg     <= (state_next != ARMED);
    end
  end

  assign SingleHitPulse = num_pulse_reg;
  assign operandHit     = op_pulse_reg;
  assign hitValid       = hit_valid_reg;
  assign hitIsOperand   = hit_is_op_reg;
  assign hitIndex       = hit_idx_reg;
  assign ropeCollision  = terr_sum_reg[2];
  assign blockCollision = terr_sum_reg[1];
  assign waterCollision = terr_sum_reg[0];
  assign hitCount       = hit_cnt_reg;
  assign inCooldown     = in_cd_reg;

endmodule

// File: tb/tb_collision_arbiter.sv
// Self-checking bench for collision_arbiter: directed scenarios plus random
// frames, all compared against a frame-level behavioural model.
module tb_collision_arbiter;

  localparam int NUM = 3;
  localparam int OPS = 2;
  localparam int CD  = 2;

  logic           clk = 1'b0;
  logic           resetN = 1'b0;
  logic           startOfFrame = 1'b0;
  logic           mon = 1'b0;
  logic [NUM-1:0] nums = '0;
  logic [OPS-1:0] ops = '0;
  logic           rope = 1'b0;
  logic           block = 1'b0;
  logic           water = 1'b0;

  logic [NUM-1:0] SingleHitPulse;
  logic [OPS-1:0] operandHit;
  logic           hitValid;
  logic           hitIsOperand;
  logic [3:0]     hitIndex;
  logic           ropeCollision;
  logic           blockCollision;
  logic           waterCollision;
  logic [7:0]     hitCount;
  logic           inCooldown;

  int tests = 0;
  int fails = 0;
  int hv_seen = 0;

  // Model: SOF edges still to pass before hits are allowed again, hit tally,
  // running terrain flags for this frame and the summary shown for it.
  int             m_wait;
  int             m_count;
  logic [2:0]     m_acc;
  logic [2:0]     m_sum;

  always #5 clk = ~clk;

  collision_arbiter #(
    .NUMBERS         (NUM),
    .OPERANDS        (OPS),
    .COOLDOWN_FRAMES (CD)
  ) dut (
    .clk                      (clk),
    .resetN                   (resetN),
    .startOfFrame             (startOfFrame),
    .drawing_request_Monkey   (mon),
    .drawing_request_Numbers  (nums),
    .drawing_request_Operands (ops),
    .drawing_request_Rope     (rope),
    .drawing_request_Block    (block),
    .drawing_request_Water    (water),
    .SingleHitPulse           (SingleHitPulse),
    .operandHit               (operandHit),
    .hitValid                 (hitValid),
    .hitIsOperand             (hitIsOperand),
    .hitIndex                 (hitIndex),
    .ropeCollision            (ropeCollision),
    .blockCollision           (blockCollision),
    .waterCollision           (waterCollision),
    .hitCount                 (hitCount),
    .inCooldown               (inCooldown)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse"}, 32'(SingleHitPulse), 0);
    check({tag, "_ophit"}, 32'(operandHit), 0);
    check({tag, "_valid"}, 32'(hitValid), 0);
    check({tag, "_isop"},  32'(hitIsOperand), 0);
    check({tag, "_idx"},   32'(hitIndex), 0);
    check({tag, "_terr"},  32'({ropeCollision, blockCollision, waterCollision}), 0);
    check({tag, "_count"}, 32'(hitCount), 0);
    check({tag, "_incd"},  32'(inCooldown), 0);
  endtask

  task automatic model_reset();
    m_wait  = 0;
    m_count = 0;
    m_acc   = '0;
    m_sum   = '0;
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic sof, input logic m, input logic [NUM-1:0] n,
                      input logic [OPS-1:0] o, input logic [2:0] terr);
    logic [NUM-1:0] on;
    logic [OPS-1:0] oo;
    logic [NUM-1:0] e_num;
    logic [OPS-1:0] e_op;
    logic           e_valid;
    logic           e_isop;
    logic [3:0]     e_idx;
    startOfFrame = sof;
    mon   = m;
    nums  = n;
    ops   = o;
    {rope, block, water} = terr;
    on = m ? n : '0;
    oo = m ? o : '0;
    e_num = '0; e_op = '0; e_valid = 1'b0; e_isop = 1'b0; e_idx = '0;
    if (!sof && m_wait == 0 && (on != '0 || oo != '0)) begin
      e_valid = 1'b1;
      if (on != '0) begin
        e_num = on & (~on + 1'b1);
        for (int i = 0; i < NUM; i++) if (e_num[i]) e_idx = 4'(i);
      end else begin
        e_isop = 1'b1;
        e_op = oo & (~oo + 1'b1);
        for (int i = 0; i < OPS; i++) if (e_op[i]) e_idx = 4'(i);
      end
      if (m_count < 255) m_count++;
      m_wait = CD + 1;
    end else if (sof && m_wait > 0) begin
      m_wait--;
    end
    if (sof) begin
      m_sum = m_acc;
      m_acc = '0;
    end else if (m) begin
      m_acc = m_acc | terr;
    end
    @(posedge clk);
    #1;
    check("pulse", 32'(SingleHitPulse), 32'(e_num));
    check("ophit", 32'(operandHit), 32'(e_op));
    check("valid", 32'(hitValid), 32'(e_valid));
    if (e_valid) begin
      check("isop", 32'(hitIsOperand), 32'(e_isop));
      check("idx", 32'(hitIndex), 32'(e_idx));
    end
    check("terr", 32'({ropeCollision, blockCollision, waterCollision}), 32'(m_sum));
    check("count", 32'(hitCount), 32'(m_count));
    check("incd", 32'(inCooldown), 32'(m_wait > 0));
    if (hitValid === 1'b1) hv_seen++;
  endtask

  task automatic idle_frame(input int len);
    step(1'b1, 1'b0, '0, '0, '0);
    for (int c = 1; c < len; c++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Asynchronous reset taken mid-cycle, away from the active edge.
  task automatic apply_reset(input string tag);
    #3;
    resetN = 1'b0;
    #1;
    check_all_zero(tag);
    startOfFrame = 1'b0; mon = 1'b0; nums = '0; ops = '0;
    {rope, block, water} = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero({tag, "_held"});
    resetN = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    apply_reset("rst0");

    // Single number hit with two candidates: lowest overlapping index wins.
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 3'b110, 2'b00, '0);
    check("r038_pulse", 32'(SingleHitPulse), 32'(3'b010));
    check("r038_idx", 32'(hitIndex), 1);
    check("r038_isop", 32'(hitIsOperand), 0);
    check("r038_count", 32'(hitCount), 1);
    step(1'b0, 1'b1, 3'b110, 2'b00, '0);
    check("r038_once", 32'(SingleHitPulse), 0);
    repeat (3) idle_frame(3);

    // Number and operand together: number wins; then cooldown over 3 frames.
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 3'b001, 2'b01, '0);
    check("r039_pulse", 32'(SingleHitPulse), 32'(3'b001));
    check("r039_ophit", 32'(operandHit), 0);
    repeat (3) step(1'b0, 1'b1, 3'b111, 2'b11, '0);
    hv_seen = 0;
    repeat (2) begin
      step(1'b1, 1'b0, '0, '0, '0);
      repeat (4) step(1'b0, 1'b1, 3'b111, 2'b11, '0);
    end
    check("r040_nohit", hv_seen, 0);
    step(1'b1, 1'b0, '0, '0, '0);
    repeat (4) step(1'b0, 1'b1, 3'b111, 2'b11, '0);
    check("r040_rehit", hv_seen, 1);

    // One rope pixel shows up for exactly the following frame.
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, '0, '0, 3'b100);
    repeat (2) step(1'b0, 1'b0, '0, '0, '0);
    idle_frame(4);
    check("r041_rope_on", 32'(ropeCollision), 1);
    idle_frame(2);
    check("r041_rope_off", 32'(ropeCollision), 0);

    // Overlaps only on the startOfFrame cycle are ignored completely.
    repeat (4) idle_frame(2);
    hv_seen = 0;
    step(1'b1, 1'b1, 3'b111, 2'b11, 3'b111);
    repeat (3) step(1'b0, 1'b0, '0, '0, '0);
    idle_frame(2);
    check("r042_nohit", hv_seen, 0);
    check("r042_terr", 32'({ropeCollision, blockCollision, waterCollision}), 0);

    // Random frames, including overlaps on startOfFrame cycles.
    for (int f = 0; f < 150; f++) begin
      int len;
      len = $urandom_range(3, 8);
      for (int c = 0; c < len; c++)
        step(c == 0, 1'($urandom_range(0, 1)), NUM'($urandom), OPS'($urandom),
             3'($urandom) & 3'($urandom));
    end

    // Enough accepted hits to saturate the counter.
    for (int k = 0; k < 3 * 262; k++) begin
      step(1'b1, 1'b0, '0, '0, '0);
      step(1'b0, 1'b1, NUM'($urandom_range(1, 7)), OPS'($urandom), '0);
      step(1'b0, 1'b0, '0, '0, '0);
    end
    check("r043_sat", 32'(hitCount), 255);

    // Reset in the middle of a cooldown with terrain pending.
    repeat (4) idle_frame(2);
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 3'b001, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, '0, '0, 3'b111);
    check("r043_pre_incd", 32'(inCooldown), 1);
    apply_reset("rst1");
    step(1'b0, 1'b1, 3'b100, '0, '0);
    check("r043_post_valid", 32'(hitValid), 1);
    check("r043_post_pulse", 32'(SingleHitPulse), 32'(3'b100));
    check("r043_post_count", 32'(hitCount), 1);
    idle_frame(3);
    check("r043_post_terr", 32'({ropeCollision, blockCollision, waterCollision}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
